muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Multi-cycle multiply/divide controller that owns the HI/LO register pair.
//  Sits beside the E-stage ALU: accepts mult/div/mthi/mtlo from E and runs a busy counter.
//  Raises a pipeline stall request while any E-stage HI/LO instruction would observe a stale or in-flight result.
//  hi/lo outputs feed the E->M pipeline register for mfhi/mflo.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   reset, synchronous, active-high
//  start      in   1   E-stage op valid this cycle (already qualified by no-stall/no-flush)
//  op         in   3   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op
//  src_a      in   32  forwarded rs value
//  src_b      in   32  forwarded rt value
//  md_use_E   in   1   E-stage instr is any of mult/div/mthi/mtlo/mfhi/mflo
//  hi         out  32  architectural HI
//  lo         out  32  architectural LO
//  busy       out  1   multi-cycle op in flight
//  stall_req  out  1   freeze F/D/E, bubble into M
// BEHAVIOUR
//  Reset: hi=0, lo=0, busy=0, counter=0, FSM=IDLE; stall_req=0 after reset edge. Reset mid-operation aborts the op.
//  FSM IDLE/RUN.
//   IDLE + start + op in {0..3}: latch result, cnt<=N (MULT_CYCLES or DIV_CYCLES), busy<=1, ->RUN.
//   IDLE + start + op=4: hi<=src_a next edge. op=5: lo<=src_a. Stay IDLE, busy stays 0.
//   IDLE + start + op in {6,7}: no effect.
//   RUN: cnt decrements each edge; on the edge where cnt==1: hi/lo<=latched result, busy<=0, ->IDLE.
//   busy is high for exactly N cycles after the start edge.
//   New hi/lo is visible in the first cycle busy=0.
//  Results, computed from operands captured at the start edge:
//   MULT  {hi,lo} = $signed(a)*$signed(b), 64-bit.
//   MULTU {hi,lo} = a*b, unsigned 64-bit.
//   DIV   lo=quotient, hi=remainder. Truncate toward zero; remainder takes the sign of the dividend.
//   DIVU  unsigned quotient and remainder.
//   Divide by zero (b==0): full busy period runs; hi/lo unchanged at completion.
//   DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  stall_req = md_use_E & (busy | (start & op<=3)). Combinational.
//   Covers back-to-back HI/LO ops and mfhi/mflo behind an in-flight op.
//  start while busy: ignored. stall_req guarantees the pipeline never issues it; assert in sim.
//  Operand changes after the start edge have no effect on the in-flight op.
//  hi/lo hold their value in every cycle not listed above.
// TESTING
//  MULT a=0xFFFFFFFE(-2) b=3, 1-cycle start -> busy 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFFA.
//  MULTU a=0xFFFFFFFF b=2 -> after 5 cycles hi=0x1 lo=0xFFFFFFFE.
//  DIV a=-7(0xFFFFFFF9) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  DIVU by 0 with hi=0x11 lo=0x22 preset via MTHI/MTLO -> after 10 cycles hi=0x11 lo=0x22.
//  DIV start, md_use_E held high (mflo waiting) -> stall_req=1 for the start cycle plus 10 busy cycles, 0 after.
//  MULT start, reset asserted on 3rd busy cycle -> next cycle busy=0 hi=0 lo=0; no late writeback.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide controller that owns the HI/LO register pair.
// Latches the result at the start edge and writes it back when the busy countdown expires.
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_use_E,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       hi_nxt, lo_nxt;
    logic [63:0]       res_p0, res_calc;
    logic              res_wr_p0, res_wr_calc;
    logic              load_res;

    function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic signed [63:0] ae, be;
        ae = {{32{a[31]}}, a};
        be = {{32{b[31]}}, b};
        return ae * be;
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Magnitude divide avoids the -2^31 / -1 overflow of a native signed divide.
    function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic [31:0] ma, mb, q, r;
        ma = a[31] ? 32'(-a) : 32'(a);
        mb = b[31] ? 32'(-b) : 32'(b);
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {a % b, a / b};
    endfunction

    always_comb begin
        res_calc    = '0;
        res_wr_calc = 1'b1;
        case (op)
            3'd0:    res_calc = mul_signed($signed(src_a), $signed(src_b));
            3'd1:    res_calc = mul_unsigned(src_a, src_b);
            3'd2: begin
                if (src_b == 32'd0) res_wr_calc = 1'b0;
                else                res_calc    = div_signed($signed(src_a), $signed(src_b));
            end
            3'd3: begin
                if (src_b == 32'd0) res_wr_calc = 1'b0;
                else                res_calc    = div_unsigned(src_a, src_b);
            end
            default: res_wr_calc = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi;
        lo_nxt    = lo;
        load_res  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1: begin
                            load_res  = 1'b1;
                            cnt_nxt   = CNT_W'(MULT_CYCLES);
                            state_nxt = RUN;
                        end
                        3'd2, 3'd3: begin
                            load_res  = 1'b1;
                            cnt_nxt   = CNT_W'(DIV_CYCLES);
                            state_nxt = RUN;
                        end
                        3'd4:    hi_nxt = src_a;
                        3'd5:    lo_nxt = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    if (res_wr_p0) begin
                        hi_nxt = res_p0[63:32];
                        lo_nxt = res_p0[31:0];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
        end
    end

    // Operand snapshot; the pipeline may change src_a/src_b freely after the start edge.
    always_ff @(posedge clk) begin
        if (load_res) begin
            res_p0    <= res_calc;
            res_wr_p0 <= res_wr_calc;
        end
    end

    assign busy      = (state == RUN);
    assign stall_req = md_use_E & (busy | (start & (op <= 3'd3)));

    always_ff @(posedge clk) begin
        if (!reset) assert (!(start && busy && (op <= 3'd5)));
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected HI/LO/busy length,
// a monitor pops and compares on each busy falling edge.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        md_use_E = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, stall_req;

    muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .md_use_E(md_use_E),
        .hi(hi), .lo(lo), .busy(busy), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic stall_at_start;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the DUT presents a result on the first cycle busy is low after a busy period.
    logic prev_busy = 1'b0;
    int   busy_len  = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            if (busy) busy_len++;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                    chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                    chk({e.name, "_busy_len"}, 64'(busy_len), 64'(e.cycles));
                end
                busy_len = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        stall_at_start = stall_req;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd7; src_a = 32'hDEAD_BEEF; src_b = 32'h0BAD_F00D;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic push(input string name, input logic [31:0] h, input logic [31:0] l, input int c);
        exp_t e;
        e.name = name; e.hi = h; e.lo = l; e.cycles = c;
        exp_q.push_back(e);
    endtask

    initial begin
        int scnt;
        md_use_E = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        md_use_E = 1'b0;

        push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_no_stall_without_use", 64'(stall_at_start), 64'd0);
        wait_done("mult");

        push("multu", 32'h0000_0001, 32'hFFFF_FFFE, 5);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_done("multu");

        // DIV with mflo waiting in E: stall covers start cycle and all 10 busy cycles.
        md_use_E = 1'b1;
        push("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_stall_start", 64'(stall_at_start), 64'd1);
        scnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stall_req) scnt++;
        end
        chk("div_stall_busy_cycles", 64'(scnt), 64'd10);
        @(negedge clk);
        chk("div_stall_after", 64'(stall_req), 64'd0);
        md_use_E = 1'b0;

        push("div_ovf", 32'h0000_0000, 32'h8000_0000, 10);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf");

        push("divu", 32'd2, 32'd14, 10);
        issue(3'd3, 32'd100, 32'd7);
        wait_done("divu");

        issue(3'd4, 32'h11, 32'h0);
        @(negedge clk);
        chk("mthi_hi", 64'(hi), 64'h11);
        chk("mthi_busy", 64'(busy), 64'd0);
        issue(3'd5, 32'h22, 32'h0);
        @(negedge clk);
        chk("mtlo_lo", 64'(lo), 64'h22);
        chk("mtlo_hi_kept", 64'(hi), 64'h11);

        push("divu_by0", 32'h11, 32'h22, 10);
        issue(3'd3, 32'd55, 32'd0);
        wait_done("divu_by0");

        issue(3'd6, 32'h99, 32'h99);
        @(negedge clk);
        chk("nop_hi", 64'(hi), 64'h11);
        chk("nop_lo", 64'(lo), 64'h22);
        chk("nop_busy", 64'(busy), 64'd0);

        // Reset lands in the 3rd busy cycle of a MULT; no result may appear afterwards.
        issue(3'd0, 32'd7, 32'd9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        repeat (8) @(negedge clk);
        chk("abort_no_late_wb", {hi, lo}, 64'd0);
        chk("abort_still_idle", 64'(busy), 64'd0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
